// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWdata = 2'd1,
        StWait  = 2'd2,
        StBurst = 2'd3
    } state_e;

    localparam int unsigned DEF_LATENCY    = 4;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned DEF_MEM_AW     = 8;
    localparam int unsigned DEF_OFFSET_W   = $clog2(DEF_LINE_WORDS);
    localparam int unsigned LAT_W          = 4;

endpackage

// File: rtl/mem_array.sv
// Backing store: synchronous write, asynchronous read, contents never reset.
module mem_array #(
    parameter int unsigned MEM_AW = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_responder.sv
// Cache-line memory responder: critical-word-first fills after a fixed latency.
// Define MEM_WRITE_EN to add line-write (eviction) support with a single ack beat.
module memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY    = DEF_LATENCY,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned MEM_AW     = DEF_MEM_AW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_last,
    output logic        busy
);

    localparam int unsigned OW = $clog2(LINE_WORDS);
    localparam int unsigned BW = OW + 1;
    localparam int unsigned LINE_AW = MEM_AW - OW;
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(LATENCY);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(LINE_WORDS - 1);
    // With zero latency the WAIT state is skipped entirely.
    localparam state_e POST_STATE = (LATENCY == 0) ? StBurst : StWait;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [LINE_AW-1:0] line_q, line_d;
    logic [OW-1:0]      off_q, off_d;
    logic               we_q;

    logic [OW-1:0]      word_sel;
    logic [MEM_AW-1:0]  mem_addr;
    logic               mem_we;
    logic [15:0]        mem_wdata;
    logic [15:0]        mem_rdata;

    // Offset wraps inside the line by truncation to OW bits.
    assign word_sel = off_q + beat_cnt_q[OW-1:0];
    assign mem_addr = {line_q, word_sel};

    logic unused_addr;
    assign unused_addr = ^req_addr;

`ifdef MEM_WRITE_EN
    logic we_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q <= 1'b0;
        end else begin
            we_q <= we_d;
        end
    end

    assign mem_we    = (state_q == StWdata) && wr_valid;
    assign mem_wdata = wr_data;
`else
    logic unused_wr;
    assign unused_wr = ^{req_we, wr_valid, wr_data};
    assign we_q      = 1'b0;
    assign mem_we    = 1'b0;
    assign mem_wdata = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            lat_cnt_q  <= '0;
            beat_cnt_q <= '0;
            line_q     <= '0;
            off_q      <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            line_q     <= line_d;
            off_q      <= off_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        beat_cnt_d = beat_cnt_q;
        line_d     = line_q;
        off_d      = off_q;
`ifdef MEM_WRITE_EN
        we_d       = we_q;
`endif
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_last   = 1'b0;
        rsp_data   = 16'h0000;
        busy       = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    line_d     = req_addr[MEM_AW-1:OW];
                    off_d      = req_addr[OW-1:0];
                    beat_cnt_d = '0;
                    lat_cnt_d  = LAT_INIT;
                    state_d    = POST_STATE;
`ifdef MEM_WRITE_EN
                    we_d = req_we;
                    if (req_we) begin
                        state_d = StWdata;
                    end
`endif
                end
            end
            StWdata: begin
`ifdef MEM_WRITE_EN
                if (wr_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        lat_cnt_d  = LAT_INIT;
                        state_d    = POST_STATE;
                    end
                end
`else
                state_d = StIdle;
`endif
            end
            StWait: begin
                if (lat_cnt_q <= LAT_W'(1)) begin
                    lat_cnt_d = '0;
                    state_d   = StBurst;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            StBurst: begin
                rsp_valid = 1'b1;
                if (we_q) begin
                    // Write acknowledge: one beat, no data.
                    rsp_last = 1'b1;
                    state_d  = StIdle;
                end else begin
                    rsp_data   = mem_rdata;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        rsp_last   = 1'b1;
                        beat_cnt_d = '0;
                        state_d    = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    mem_array #(
        .MEM_AW (MEM_AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter LATENCY, default 4, wait cycles between request/write-data completion and the first response beat; legal range 0..15.
REQ-002 Parameter LINE_WORDS, default 4, 16-bit words per cache line; power of two, 2..8.
REQ-003 Parameter MEM_AW, default 8, word-address width of the backing store (2^MEM_AW words).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  cache presents a line request.
REQ-007 req_ready  output  1  responder accepts a request this cycle.
REQ-008 req_addr  input  16  word address; low log2(LINE_WORDS) bits select the critical word.
REQ-009 req_we  input  1  1 = line write (eviction), 0 = line fill.
REQ-010 wr_valid  input  1  write-data beat present.
REQ-011 wr_data  input  16  write-data beat.
REQ-012 rsp_valid  output  1  response beat valid; no backpressure, cache always accepts.
REQ-013 rsp_data  output  16  fill word; 0 when rsp_valid=0 and on write acks.
REQ-014 rsp_last  output  1  final beat of a response.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, WDATA, WAIT, BURST; req_ready=1 only in IDLE (combinational from state).
REQ-017 Request accepted on req_valid&&req_ready; req_addr and req_we captured into registers at that edge.
REQ-018 Address: word index = req_addr[MEM_AW-1:0]; upper bits ignored (aliasing); line base = index with offset bits cleared.
REQ-019 Read accepted at cycle T: WAIT for LATENCY cycles, then BURST for exactly LINE_WORDS consecutive cycles; first beat at T+LATENCY+1 (LATENCY=0 -> T+1, WAIT skipped).
REQ-020 Burst order critical-word-first: beat i returns mem[base + ((offset+i) mod LINE_WORDS)]; offset wraps inside the line, never into the next line.
REQ-021 rsp_last=1 only on beat LINE_WORDS-1; state returns to IDLE on the following edge, so req_ready is high the cycle after rsp_last.
REQ-022 Write accepted: WDATA collects LINE_WORDS beats, one per cycle with wr_valid=1 (gaps allowed), stored in the same wrap order as REQ-020; each beat written at its edge.
REQ-023 After last write beat at cycle W: WAIT LATENCY cycles, then single ack beat at W+LATENCY+1 with rsp_valid=1, rsp_last=1, rsp_data=0.
REQ-024 wr_valid outside WDATA ignored; req_valid outside IDLE ignored (not queued).
REQ-025 Latency counter 4 bits, loaded with LATENCY, decrements to 0; beat counter log2(LINE_WORDS)+1 bits.

Reset
REQ-026 reset forces IDLE, counters 0, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0; req_ready=1 the cycle after reset deasserts.
REQ-027 Reset mid-burst or mid-WDATA abandons the transaction: no further rsp_valid; words already written persist; no ack issued.
REQ-028 Memory array contents not reset.

Configuration
REQ-029 Macro MEM_WRITE_EN: when defined, REQ-022/023 apply; when undefined, req_we is ignored, every request is a read fill, WDATA absent, wr_valid/wr_data unused, array written only by bench backdoor.

Structure
REQ-030 Shared package mem_pkg holds the state enum, default LATENCY/LINE_WORDS/MEM_AW constants, and the offset-width constant.
REQ-031 One sub-module mem_array: 2^MEM_AW x 16 storage, synchronous write, asynchronous read, no reset.

Verification
REQ-032 Reset during beat 2 of a read -> rsp_valid 0 from next cycle, busy 0, req_ready 1 after release.
REQ-033 MEM_WRITE_EN, LATENCY=4: write 0x0010, beats 0xA0..0xA3 ending at cycle W -> single ack at W+5, rsp_data=0, rsp_last=1.
REQ-034 Then read 0x0012 accepted at T -> beats 0xA2,0xA3,0xA0,0xA1 at T+5..T+8, rsp_last only at T+8.
REQ-035 req_valid held high over two reads -> second accepted the cycle after the first rsp_last, no idle gap beyond that.
REQ-036 MEM_AW=8: read 0x0110 returns same data as 0x0010; LATENCY=0 read gives first beat at T+1.
REQ-037 MEM_WRITE_EN undefined: req_we=1 at 0x0010 with wr_valid pulses -> normal read burst of existing data, array unchanged.
